// File: rtl/ray_job_dispatcher.sv
// Round-robin dispatcher of ray jobs from one job generator onto
// NUM_CORES job-interface / DDA stepper cores, with frame drain tracking.
//
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   in_valid/in_ready  : upstream job handshake; in_job/in_last sampled on accept
//   core_enable        : per-core enable mask (disabled cores never granted)
//   core_valid/ready   : one-hot job valid to core i / per-core job_ready
//   core_job           : held job broadcast to every core
//   core_done          : per-core completion pulse
//   core_busy          : core holds a dispatched, uncompleted job
//   outstanding        : number of dispatched, uncompleted jobs
//   dispatch_count     : jobs dispatched since reset (wraps)
//   frame_done         : one-cycle pulse once a frame fully drains
//   err_spurious       : sticky flag, core_done seen on a non-busy core

module ray_job_dispatcher #(
   parameter int W = 24,
   parameter int NUM_CORES = 4,
   localparam int JOB_W = 28 + 6 * W,
   localparam int CW = $clog2(NUM_CORES + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [JOB_W-1:0]     in_job,
   input  logic                 in_last,
   input  logic [NUM_CORES-1:0] core_enable,
   output logic [NUM_CORES-1:0] core_valid,
   input  logic [NUM_CORES-1:0] core_ready,
   output logic [JOB_W-1:0]     core_job,
   input  logic [NUM_CORES-1:0] core_done,
   output logic [NUM_CORES-1:0] core_busy,
   output logic [CW-1:0]        outstanding,
   output logic [15:0]          dispatch_count,
   output logic                 frame_done,
   output logic                 err_spurious
);

   localparam int PW = $clog2(NUM_CORES);
   localparam logic [PW:0]   NC    = (PW + 1)'(NUM_CORES);
   localparam logic [PW-1:0] LASTP = PW'(NUM_CORES - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DISPATCH = 2'd1;
   localparam logic [1:0] S_DRAIN    = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   logic [1:0]           state;
   logic [1:0]           state_next;
   logic [JOB_W-1:0]     job_buf;
   logic                 buf_last;
   logic [PW-1:0]        rr_ptr;
   logic [NUM_CORES-1:0] busy;
   logic [CW-1:0]        out_cnt;
   logic [15:0]          disp_cnt;
   logic                 err_q;

   logic [NUM_CORES-1:0]   avail;
   logic [2*NUM_CORES-1:0] avail2;
   logic [NUM_CORES-1:0]   rot;
   logic                   found;
   logic [PW-1:0]          off;
   logic [PW:0]            sum;
   logic [PW-1:0]          grant_idx;
   logic [NUM_CORES-1:0]   grant_oh;
   logic                   xfer;
   logic [NUM_CORES-1:0]   done_ok;
   logic [NUM_CORES-1:0]   done_bad;
   logic [CW-1:0]          done_cnt;
   logic [CW-1:0]          out_next;

   // Rotate the availability mask so bit 0 is the core at rr_ptr;
   // the lowest set bit of the rotated mask is the grant offset.
   always_comb begin
      avail  = core_enable & core_ready & ~busy;
      avail2 = {avail, avail};
      rot    = NUM_CORES'(avail2 >> rr_ptr);
      found  = |rot;
      off    = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (rot[k]) off = PW'(k);
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= NC) sum = sum - NC;
      grant_idx = sum[PW-1:0];
      grant_oh  = found ? (NUM_CORES'(1) << grant_idx) : '0;
   end

   assign xfer = (state == S_DISPATCH) && found;

   // Only dones on busy cores count; the rest are flagged as spurious.
   always_comb begin
      done_ok  = core_done & busy;
      done_bad = core_done & ~busy;
      done_cnt = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         done_cnt = done_cnt + CW'(done_ok[k]);
      end
      out_next = out_cnt + CW'(xfer) - done_cnt;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:     if (in_valid) state_next = S_DISPATCH;
         S_DISPATCH: if (xfer) state_next = buf_last ? S_DRAIN : S_IDLE;
         S_DRAIN:    if (out_next == '0) state_next = S_DONE;
         S_DONE:     state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         job_buf  <= '0;
         buf_last <= 1'b0;
         rr_ptr   <= '0;
         busy     <= '0;
         out_cnt  <= '0;
         disp_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && in_valid) begin
            job_buf  <= in_job;
            buf_last <= in_last;
         end
         if (xfer) begin
            rr_ptr   <= (grant_idx == LASTP) ? '0 : grant_idx + PW'(1);
            disp_cnt <= disp_cnt + 16'd1;
         end
         busy    <= (busy & ~done_ok) | (xfer ? grant_oh : '0);
         out_cnt <= out_next;
         if (|done_bad) err_q <= 1'b1;
      end
   end

   assign in_ready       = (state == S_IDLE);
   assign core_valid     = xfer ? grant_oh : '0;
   assign core_job       = job_buf;
   assign core_busy      = busy;
   assign outstanding    = out_cnt;
   assign dispatch_count = disp_cnt;
   assign frame_done     = (state == S_DONE);
   assign err_spurious   = err_q;

endmodule

// File: doc/ray_job_dispatcher.md
# ray_job_dispatcher

Distributes ray jobs from a single upstream job generator across NUM_CORES parallel ray-job interface / DDA stepper cores, round-robin over enabled, ready cores. It sits between the camera/pixel job generator and the bank of per-core job interfaces. It tracks outstanding jobs per core and signals frame completion once the last job of a frame has been dispatched and every core has reported done.

## Interface
- W, 24: fixed-point timer width, matching the per-core job interface.
- NUM_CORES, 4: number of downstream cores, 2..8.
- JOB_W (localparam), 28+6*W: packed job width; field order MSB→LSB is ix0[5], iy0[5], iz0[5], sx, sy, sz, next_x, next_y, next_z, inc_x, inc_y, inc_z, max_steps[10].

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream job valid.
- in_ready  out  1  dispatcher can accept a job.
- in_job  in  JOB_W  packed job.
- in_last  in  1  job is the last of the frame; sampled with in_job.
- core_enable  in  NUM_CORES  per-core enable mask; disabled cores never granted.
- core_valid  out  NUM_CORES  one-hot job valid to core i.
- core_ready  in  NUM_CORES  per-core job_ready.
- core_job  out  JOB_W  job bus broadcast to all cores.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_busy  out  NUM_CORES  core holds a dispatched, uncompleted job.
- outstanding  out  $clog2(NUM_CORES+1)  count of dispatched, uncompleted jobs.
- dispatch_count  out  16  total jobs dispatched since reset; wraps at 2^16.
- frame_done  out  1  one-cycle pulse when a frame fully drains.
- err_spurious  out  1  sticky: core_done seen on a non-busy core.

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid, latch in_job→job_buf and in_last→buf_last; go to DISPATCH.
- DISPATCH: in_ready=0; core_job=job_buf.
  - Grant g = first index at or after rr_ptr (wrapping) with core_enable[g] && core_ready[g] && !core_busy[g].
  - If a grant exists: core_valid[g]=1 for that cycle; the transfer completes at that edge.
  - On transfer: core_busy[g] set; rr_ptr ← (g+1) mod NUM_CORES; dispatch_count++; outstanding++. Next state is DRAIN if buf_last, else IDLE.
  - No grant: hold with core_valid=0. No timeout; if all cores are disabled, the job is held until one is enabled.
- DRAIN: in_ready=0. When outstanding is 0 after this cycle's updates, go to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE.
- core_done[i] clears core_busy[i] and decrements outstanding by popcount of the valid done bits. This holds in every state.
  - A dispatch to core i and core_done[j] in the same cycle: net outstanding = +1 − popcount.
  - core_done[i] while core_busy[i]=0: ignored for counting; sets err_spurious, which clears only on reset.
- core_valid depends only on state, busy, enable, ready and rr_ptr, never on in_valid.
- core_job is driven from job_buf only. It holds its value outside DISPATCH and is 0 after reset.

## Timing
- Reset values:
  - State IDLE, in_ready=1.
  - core_valid=0, core_job=0, core_busy=0.
  - outstanding=0, dispatch_count=0.
  - frame_done=0, err_spurious=0, rr_ptr=0.
- Reset mid-operation abandons the held job and all tracking. Downstream cores are reset by the same signal.
- Accept at edge T: core_valid is asserted during cycle T+1 if a core is available, and the core latches at edge T+1.
- Maximum throughput is one job per 2 cycles.
- core_busy[g] rises the cycle after the transfer.
- Last-job drain: frame_done asserts one cycle after the cycle in which outstanding reaches 0.

## Test plan
- Round-robin: all 4 cores enabled and ready, 8 back-to-back jobs with in_valid held high → grants 0,1,2,3 then blocked, since busy cores are skipped. Completing cores 0..3 then yields grants 0,1,2,3 again; dispatch_count=8.
- Backpressure: all cores busy, one job held in DISPATCH for 20 cycles → in_ready=0, core_valid=0, core_job stable. core_done[2] → grant to core 2 the next cycle.
- Enable mask: core_enable=4'b1010, 4 jobs → grants alternate 1,3. core_valid[0] and core_valid[2] are never asserted.
- Simultaneous events: dispatch to core 1 in the same cycle as core_done on cores 0 and 3, with outstanding=3 before → outstanding=2. Spurious core_done[2] → err_spurious=1 and outstanding unchanged.
- Frame drain: 3 jobs, the third with in_last=1 → DRAIN, in_ready=0. After the last core_done, outstanding=0 and frame_done pulses exactly one cycle; in_ready=1 the cycle after the pulse.
- Reset mid-operation: reset asserted in DRAIN with outstanding=2 → the next cycle shows every output at its reset value and in_ready=1.
